sel_unbuffer: RTL and testbench

Frame-based reorder buffer that restores natural sample order from a pair-swapped stream, where each frame arrives as 1,0,3,2,…,SIZE-1,SIZE-2. It sits on the receive side of the selector path and undoes the pair-swap ordering applied upstream. It writes each frame into one of two ping-pong banks at scrambled addresses and reads a completed bank linearly. Valid/ready handshakes on both sides allow back-pressure without sample loss.

---
 rtl/sel_unbuffer.sv | 98 +++++++++
 tb/tb_sel_unbuffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_unbuffer.sv
// Ping-pong reorder buffer that restores natural order from a pair-swapped sample stream.
// Define SEL_UNBUFFER_LAST_EN to build a registered end-of-frame flag on out_last.
module sel_unbuffer #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int unsigned IW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(SIZE - 1);

  logic signed [WIDTH-1:0] mem_q [2][SIZE];

  logic          wr_bank_q, rd_bank_q;
  logic [IW-1:0] wr_idx_q, rd_idx_q;
  logic [1:0]    full_q, full_d;
  logic          wr_fire, load;
  logic          wr_last, rd_last;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign load     = full_q[rd_bank_q] && (!out_valid || out_ready);
  assign wr_last  = (wr_idx_q == LastIdx);
  assign rd_last  = (rd_idx_q == LastIdx);

  // Writer only targets a non-full bank and reader only a full one, so set/clear never collide.
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    if (load && rd_last)    full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_idx_q ^ IW'(1)] <= in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      full_q    <= 2'b00;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        if (wr_last) begin
          wr_idx_q  <= '0;
          wr_bank_q <= !wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + IW'(1);
        end
      end
      if (load) begin
        out       <= mem_q[rd_bank_q][rd_idx_q];
        out_valid <= 1'b1;
        if (rd_last) begin
          rd_idx_q  <= '0;
          rd_bank_q <= !rd_bank_q;
        end else begin
          rd_idx_q <= rd_idx_q + IW'(1);
        end
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEL_UNBUFFER_LAST_EN
  logic out_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_last_q <= 1'b0;
    end else if (load) begin
      out_last_q <= rd_last;
    end else if (out_ready && out_valid) begin
      out_last_q <= 1'b0;
    end
  end

  assign out_last = out_last_q;
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_sel_unbuffer.sv
// Directed and randomized-handshake bench for sel_unbuffer (SIZE=4, WIDTH=8).
module tb_sel_unbuffer;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [WIDTH-1:0] in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic signed [WIDTH-1:0] send_q[$];
  logic signed [WIDTH-1:0] got_q[$];
  logic                    last_q[$];
  int                      cons_cyc_q[$];

  always #5 clk = ~clk;

  sel_unbuffer #(
    .SIZE (SIZE),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  function automatic logic exp_last(input int idx);
`ifdef SEL_UNBUFFER_LAST_EN
    return (idx % SIZE) == SIZE - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle: present head of send_q, record consumed outputs, then advance past the edge.
  task automatic drive_cycle(input bit vld_en, input bit rdy, output bit acc);
    bit cons;
    in_valid  = vld_en && (send_q.size() != 0);
    in        = (send_q.size() != 0) ? send_q[0] : '0;
    out_ready = rdy;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    if (cons) begin
      got_q.push_back(out);
      last_q.push_back(out_last);
      cons_cyc_q.push_back(cyc);
    end
    step();
    if (acc) void'(send_q.pop_front());
  endtask

  task automatic assert_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    send_q.delete();
    got_q.delete();
    last_q.delete();
    cons_cyc_q.delete();
  endtask

  task automatic test_reset();
    assert_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out !== 8'sd0) begin
      failures++; $display("FAIL reset_out: got %0d want 0", out);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out_last: got %b want 0", out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    release_reset();
  endtask

  task automatic test_single_frame();
    logic signed [WIDTH-1:0] exp_v [4];
    int acc_cyc   = -1;
    int first_cyc = -1;
    bit a, last_sample;
    exp_v = '{10, 11, 12, 13};
    assert_reset();
    release_reset();
    send_q = '{11, 10, 13, 12};
    for (int i = 0; i < 20; i++) begin
      last_sample = (send_q.size() == 1);
      drive_cycle(1'b1, 1'b1, a);
      if (a && last_sample) acc_cyc = cyc;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
    end
    checks++;
    if (acc_cyc < 0 || first_cyc != acc_cyc + 1) begin
      failures++;
      $display("FAIL single_latency: out_valid rose at %0d want %0d", first_cyc, acc_cyc + 1);
    end
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL single_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_v[i]) begin
        failures++; $display("FAIL single_data[%0d]: got %0d want %0d", i, got_q[i], exp_v[i]);
      end
      checks++;
      if (last_q[i] !== exp_last(i)) begin
        failures++; $display("FAIL single_last[%0d]: got %b want %b", i, last_q[i], exp_last(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [WIDTH-1:0] exp_v [8];
    bit a;
    bit gap = 1'b0;
    exp_v = '{10, 11, 12, 13, 20, 21, 22, 23};
    assert_reset();
    release_reset();
    send_q = '{11, 10, 13, 12, 21, 20, 23, 22};
    for (int i = 0; i < 30; i++) drive_cycle(1'b1, 1'b1, a);
    checks++;
    if (got_q.size() != 8) begin
      failures++; $display("FAIL b2b_count: got %0d want 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_v[i]) begin
        failures++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got_q[i], exp_v[i]);
      end
      if (i > 0 && cons_cyc_q[i] != cons_cyc_q[0] + i) gap = 1'b1;
    end
    checks++;
    if (gap) begin
      failures++; $display("FAIL b2b_bubble: got gap in output stream want none");
    end
  endtask

  task automatic test_full();
    logic signed [WIDTH-1:0] exp_v [8];
    bit a;
    bit any_acc = 1'b0;
    bit seen13  = 1'b0;
    bit early   = 1'b0;
    int n_acc   = 0;
    exp_v = '{10, 11, 12, 13, 20, 21, 22, 23};
    assert_reset();
    release_reset();
    send_q = '{11, 10, 13, 12, 21, 20, 23, 22, 99};
    for (int i = 0; i < 20 && n_acc < 8; i++) begin
      drive_cycle(1'b1, 1'b0, a);
      if (a) n_acc++;
    end
    checks++;
    if (n_acc != 8) begin
      failures++; $display("FAIL full_accepts: got %0d want 8", n_acc);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_in_ready: got %b want 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, a);
      if (a) any_acc = 1'b1;
    end
    checks++;
    if (any_acc || send_q.size() != 1) begin
      failures++; $display("FAIL full_ninth: got accepted=%b want 0", any_acc);
    end
    checks++;
    if (out_valid !== 1'b1 || out !== 8'sd10) begin
      failures++; $display("FAIL full_hold: got valid=%b out=%0d want valid=1 out=10", out_valid, out);
    end
    send_q.delete();
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b1, a);
      if (!seen13) begin
        if (out_valid && out == 8'sd13) begin
          seen13 = 1'b1;
          checks++;
          if (in_ready !== 1'b1) begin
            failures++; $display("FAIL full_ready_return: got %b want 1", in_ready);
          end
        end else if (in_ready) begin
          early = 1'b1;
        end
      end
    end
    checks++;
    if (!seen13 || early) begin
      failures++; $display("FAIL full_ready_timing: got seen13=%b early=%b want 1 0", seen13, early);
    end
    checks++;
    if (got_q.size() != 8) begin
      failures++; $display("FAIL full_drain_count: got %0d want 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_v[i]) begin
        failures++; $display("FAIL full_drain[%0d]: got %0d want %0d", i, got_q[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 50 * SIZE;
    logic signed [WIDTH-1:0] nat [N];
    bit a;
    assert_reset();
    release_reset();
    for (int i = 0; i < N; i++) nat[i] = WIDTH'($urandom);
    nat[0] = -8'sd128;
    nat[1] = 8'sd127;
    nat[6] = 8'sd127;
    nat[7] = -8'sd128;
    for (int i = 0; i < N; i++) send_q.push_back(nat[i ^ 1]);
    for (int i = 0; i < 5000 && got_q.size() < N; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
    end
    checks++;
    if (got_q.size() != N) begin
      failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), N);
    end
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== nat[i] || last_q[i] !== exp_last(i)) begin
        failures++;
        $display("FAIL rand_data[%0d]: got %0d last=%b want %0d last=%b", i, got_q[i], last_q[i],
                 nat[i], exp_last(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [WIDTH-1:0] exp_v [4];
    bit a;
    exp_v = '{30, 31, 32, 33};
    assert_reset();
    release_reset();
    send_q = '{41, 40};
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1, a);
    in_valid = 1'b0;
    #2;
    assert_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_async: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    release_reset();
    send_q = '{31, 30, 33, 32};
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1, a);
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL mid_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_v[i]) begin
        failures++; $display("FAIL mid_data[%0d]: got %0d want %0d", i, got_q[i], exp_v[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
